// File: rtl/q_8_22_pkg.sv
// Shared datapath package: operand width and the multiplier-arbiter state type.
package q_8_22_pkg;

  localparam int unsigned dp_width = 8;

  typedef enum logic [1:0] {
    A_IDLE,
    A_LAUNCH,
    A_WAIT,
    A_DONE
  } arb_state_t;

endpackage

// File: rtl/q_8_22_rr_pick.sv
// Combinational round-robin selector: first set request at or after the pointer, cyclically.
module q_8_22_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             valid_o,
  output logic [IW-1:0]    winner_o
);

  logic [IW-1:0] idx;

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = IW'((32'(ptr_i) + k) % N_REQ);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/q_8_22_mult_arb.sv
// Round-robin arbiter/sequencer sharing one start/rdy multiplier among N_REQ requesters.
// Optional WAIT watchdog with err output is enabled by defining Q_8_22_MULT_ARB_TIMEOUT_EN.
module q_8_22_mult_arb
  import q_8_22_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DP_WIDTH = dp_width
`ifdef Q_8_22_MULT_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DP_WIDTH-1:0] op_a,
  input  logic [N_REQ*DP_WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [2*DP_WIDTH-1:0]     result,
  output logic                      busy,
  output logic                      mult_start,
  output logic [DP_WIDTH-1:0]       mult_a,
  output logic [DP_WIDTH-1:0]       mult_b,
  input  logic [2*DP_WIDTH-1:0]     mult_product,
  input  logic                      mult_rdy
`ifdef Q_8_22_MULT_ARB_TIMEOUT_EN
  ,
  output logic                      err
`endif
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [DP_WIDTH-1:0]   mult_a_q, mult_a_d;
  logic [DP_WIDTH-1:0]   mult_b_q, mult_b_d;
  logic [2*DP_WIDTH-1:0] result_q, result_d;

  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;
  logic [DP_WIDTH-1:0]   sel_a, sel_b;

`ifdef Q_8_22_MULT_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign err = err_q;
`endif

  q_8_22_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_a = op_a[i*DP_WIDTH +: DP_WIDTH];
        sel_b = op_b[i*DP_WIDTH +: DP_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    result_d = result_q;
`ifdef Q_8_22_MULT_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      A_IDLE: begin
        if (pick_valid && mult_rdy) begin
          owner_d  = pick_idx;
          mult_a_d = sel_a;
          mult_b_d = sel_b;
          state_d  = A_LAUNCH;
        end
      end
      A_LAUNCH: begin
        state_d = A_WAIT;
`ifdef Q_8_22_MULT_ARB_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = 1'b0;
`endif
      end
      A_WAIT: begin
        if (mult_rdy) begin
          result_d = mult_product;
          state_d  = A_DONE;
        end
`ifdef Q_8_22_MULT_ARB_TIMEOUT_EN
        // cnt_q counts elapsed WAIT cycles; the TIMEOUT_CYCLES-th one without rdy aborts
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = A_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      A_DONE: begin
        ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = A_IDLE;
      end
      default: state_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= A_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      mult_a_q <= '0;
      mult_b_q <= '0;
      result_q <= '0;
`ifdef Q_8_22_MULT_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      result_q <= result_d;
`ifdef Q_8_22_MULT_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    if (state_q == A_LAUNCH) gnt  = ONE_HOT0 << owner_q;
    if (state_q == A_DONE)   done = ONE_HOT0 << owner_q;
  end

  assign busy       = (state_q != A_IDLE);
  assign mult_start = (state_q == A_LAUNCH);
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign result     = result_q;

endmodule
